// File: rtl/mx11_seq.sv
// mx11_seq: instruction sequencer feeding the MX11 single-execute unit.
// Fetches 16-bit words over a req/ack handshake, decodes them, fetches the
// LDI immediate, and strobes the execute unit for one cycle per instruction.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   run                start/resume sequencing (sampled in IDLE/HALT only)
//   pc_load/_val       PC load (honoured in IDLE/HALT only, beats run)
//   imem_req/addr      instruction memory request, addr always equals PC
//   imem_rdata/ack     memory response, rdata valid with ack
//   fetch, ldi, ldv    execute-unit write enable, immediate select, immediate
//   opcode, src_a/b    ALU opcode and operand register indices
//   dst_f, cs_n        destination index, ALU chip select (active low)
//   pc, busy, halted   status
module mx11_seq #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_load_val,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_rdata,
  input  logic                imem_ack,
  output logic                fetch,
  output logic                ldi,
  output logic [7:0]          ldv,
  output logic [3:0]          opcode,
  output logic [3:0]          src_a,
  output logic [3:0]          src_b,
  output logic [3:0]          dst_f,
  output logic                cs_n,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IMM, S_EXEC, S_HALT
  } state_t;

  state_t              r_state, w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_ir;
  logic [7:0]          r_ldv;
  logic [3:0]          r_src_a, r_src_b, r_dst_f;

  logic w_op0, w_is_ldi, w_is_mov, w_is_halt, w_stopped, w_mem_phase;

  // Opcode 0 is the control group; its src_b field picks the action.
  assign w_op0     = (r_ir[15:12] == 4'h0);
  assign w_is_ldi  = w_op0 && (r_ir[3:0] == 4'h1);
  assign w_is_mov  = w_op0 && (r_ir[3:0] == 4'h2);
  assign w_is_halt = w_op0 && (r_ir[3:0] == 4'hF);

  assign w_stopped   = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_IMM);

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    cs_n     = 1'b1;
    opcode   = 4'h0;
    fetch    = 1'b0;
    ldi      = 1'b0;
    busy     = 1'b1;
    halted   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (!pc_load && run) w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_ldi)       w_next = S_IMM;
        else if (w_is_halt) w_next = S_HALT;
        else                w_next = S_EXEC;
      end
      S_IMM: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = S_EXEC;
      end
      S_EXEC: begin
        cs_n   = 1'b0;
        opcode = r_ir[15:12];
        fetch  = w_is_ldi || w_is_mov;
        ldi    = w_is_ldi;
        w_next = S_FETCH;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (!pc_load && run) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_ldv   <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst_f <= '0;
    end else begin
      r_state <= w_next;
      if (w_stopped && pc_load)
        r_pc <= pc_load_val;
      else if (w_mem_phase && imem_ack)
        r_pc <= r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};  // wraps naturally
      if (r_state == S_FETCH && imem_ack) r_ir  <= imem_rdata;
      if (r_state == S_IMM && imem_ack)   r_ldv <= imem_rdata[7:0];
      if (r_state == S_DECODE) begin
        r_dst_f <= r_ir[11:8];
        r_src_a <= r_ir[7:4];
        r_src_b <= r_ir[3:0];
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ldv       = r_ldv;
  assign src_a     = r_src_a;
  assign src_b     = r_src_b;
  assign dst_f     = r_dst_f;

endmodule

// File: tb/tb_mx11_seq.sv
module tb_mx11_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_load_val = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        fetch, ldi, cs_n, busy, halted;
  logic [7:0]  ldv, pc;
  logic [3:0]  opcode, src_a, src_b, dst_f;

  mx11_seq #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .fetch(fetch), .ldi(ldi), .ldv(ldv), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst_f(dst_f), .cs_n(cs_n), .pc(pc),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctl(input logic [3:0] op, d, a, b, input logic f, l);
    return {14'd0, op, d, a, b, f, l};
  endfunction

  logic [15:0] mem [256];
  logic [7:0]  exp_req [$];
  logic [31:0] exp_ctl [$];
  logic [31:0] exp_lp  [$];
  int          exec_t  [$];
  int          ack_dly = 0;
  int          wcnt = 0;
  int          cyc = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [7:0]  prev_addr = '0;

  // Memory responder and output monitor share one negedge process.
  always @(negedge clk) begin
    cyc++;
    if (!rst && prev_req && !prev_ack) begin
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", {24'd0, imem_addr}, {24'd0, prev_addr});
    end
    if (imem_req) begin
      if (wcnt == ack_dly) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        wcnt       = 0;
        if (exp_req.size() == 0) chk("req_unexpected", exp_req.size(), 32'd1);
        else chk("req_addr", {24'd0, imem_addr}, {24'd0, exp_req.pop_front()});
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end
    if (!cs_n) begin
      exec_t.push_back(cyc);
      if (exp_ctl.size() == 0) chk("exec_unexpected", exp_ctl.size(), 32'd1);
      else begin
        chk("exec_ctl", ctl(opcode, dst_f, src_a, src_b, fetch, ldi), exp_ctl.pop_front());
        chk("exec_ldv_pc", {16'd0, ldv, pc}, exp_lp.pop_front());
      end
    end else begin
      if (fetch || ldi || opcode != 4'h0)
        chk("strobe_idle", {26'd0, fetch, ldi, opcode}, 32'd0);
    end
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
  end

  task automatic push_exec(input logic [31:0] c, input logic [7:0] v, input logic [7:0] p);
    exp_ctl.push_back(c);
    exp_lp.push_back({16'd0, v, p});
  endtask

  task automatic do_reset(input int dly);
    @(negedge clk);
    rst = 1'b1;
    ack_dly = dly;
    for (int i = 0; i < 256; i++) mem[i] = 16'h000F;
    @(negedge clk);
    exp_req.delete(); exp_ctl.delete(); exp_lp.delete(); exec_t.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic load_pc(input logic [7:0] v, input logic with_run);
    @(negedge clk); pc_load = 1'b1; pc_load_val = v; run = with_run;
    @(negedge clk); pc_load = 1'b0; run = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 200) begin @(negedge clk); n++; end
    if (!halted) chk({tag, "_halt_timeout"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_req_left"}, exp_req.size(), 32'd0);
    chk({tag, "_exec_left"}, exp_ctl.size(), 32'd0);
  endtask

  task automatic chk_gap(input string tag, input int exp);
    if (exec_t.size() >= 2) chk(tag, exec_t[1] - exec_t[0], exp);
    else chk(tag, exec_t.size(), 32'd2);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_outs", {19'd0, imem_req, fetch, ldi, cs_n, busy, halted, opcode, 4'h0},
        {19'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0});
    chk("rst_regs", {ldv, src_a, src_b, dst_f, pc, 4'h0}, 32'd0);

    // Ordinary op then NOP, zero wait: 3 cycles each
    do_reset(0);
    mem[8'h00] = 16'h1312; mem[8'h01] = 16'h0000;
    exp_req.push_back(8'h00); exp_req.push_back(8'h01); exp_req.push_back(8'h02);
    push_exec(ctl(4'h1, 4'h3, 4'h1, 4'h2, 1'b0, 1'b0), 8'h00, 8'h01);
    push_exec(ctl(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0), 8'h00, 8'h02);
    pulse_run();
    wait_halt("t1");
    chk_gap("t1_gap", 3);
    chk("t1_pc", {24'd0, pc}, 32'h03);
    end_checks("t1");

    // NOP then LDI: LDI costs 4 cycles
    do_reset(0);
    mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0501; mem[8'h02] = 16'h00A5;
    for (int i = 0; i < 4; i++) exp_req.push_back(8'(i));
    push_exec(ctl(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0), 8'h00, 8'h01);
    push_exec(ctl(4'h0, 4'h5, 4'h0, 4'h1, 1'b1, 1'b1), 8'hA5, 8'h03);
    pulse_run();
    wait_halt("t2");
    chk_gap("t2_gap", 4);
    chk("t2_pc", {24'd0, pc}, 32'h04);
    end_checks("t2");

    // HALT, then pc_load beats run, then resume from loaded PC
    do_reset(0);
    exp_req.push_back(8'h00);
    pulse_run();
    wait_halt("t3");
    chk("t3_pc", {24'd0, pc}, 32'h01);
    repeat (5) @(negedge clk);
    chk("t3_still_halted", {30'd0, halted, busy}, 32'b10);
    load_pc(8'h40, 1'b1);
    @(negedge clk);
    chk("t3_load_prio", {23'd0, halted, pc}, {23'd0, 1'b1, 8'h40});
    exp_req.push_back(8'h40);
    pulse_run();
    wait_halt("t3b");
    chk("t3_pc2", {24'd0, pc}, 32'h41);
    end_checks("t3");

    // 3 wait cycles per access: ordinary op then MOV, 6 cycles apart
    do_reset(3);
    mem[8'h00] = 16'h2345; mem[8'h01] = 16'h0412;
    for (int i = 0; i < 3; i++) exp_req.push_back(8'(i));
    push_exec(ctl(4'h2, 4'h3, 4'h4, 4'h5, 1'b0, 1'b0), 8'h00, 8'h01);
    push_exec(ctl(4'h0, 4'h4, 4'h1, 4'h2, 1'b1, 1'b0), 8'h00, 8'h02);
    pulse_run();
    wait_halt("t4");
    chk_gap("t4_gap", 6);
    end_checks("t4");

    // LDI at FF takes its immediate from 00
    do_reset(0);
    mem[8'hFF] = 16'h0201; mem[8'h00] = 16'h0077; mem[8'h01] = 16'h000F;
    exp_req.push_back(8'hFF); exp_req.push_back(8'h00); exp_req.push_back(8'h01);
    push_exec(ctl(4'h0, 4'h2, 4'h0, 4'h1, 1'b1, 1'b1), 8'h77, 8'h01);
    load_pc(8'hFF, 1'b0);
    pulse_run();
    wait_halt("t5");
    chk("t5_pc", {24'd0, pc}, 32'h02);
    end_checks("t5");

    // Reset during an IMM wait
    do_reset(3);
    mem[8'h00] = 16'h0501;
    exp_req.push_back(8'h00); exp_req.push_back(8'h01);
    pulse_run();
    begin
      int n = 0;
      while (!(imem_req && imem_addr == 8'h01) && n < 50) begin @(negedge clk); n++; end
      chk("t6_reach_imm", {31'd0, imem_req && imem_addr == 8'h01}, 32'd1);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_outs", {26'd0, imem_req, cs_n, busy, halted, fetch, ldi}, 32'b010000);
    chk("t6_rst_pc", {24'd0, pc}, 32'h00);
    chk("t6_rst_ldv", {24'd0, ldv}, 32'h00);
    chk("t6_imm_pending", exp_req.size(), 32'd1);
    exp_req.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_idle", {23'd0, busy, pc}, 32'd0);
    end_checks("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
